// File: rtl/matrix_scan_selector.sv
// matrix_scan_selector
//   Time-multiplexed scan driver for the LED dot matrix. A dwell counter holds
//   each column lit for SCAN_DIV clocks and then steps a column scanner. The
//   column enable and row pattern are registered from the scanner position, so
//   they are one cycle behind it. A cursor/mode value loaded by the control FSM
//   goes into a pending shadow register. It is copied to the active register
//   only at a frame boundary, so a frame never shows a mix of old and new
//   cursor. A frame counter drives the blink phase used by mode 11.
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   en         1 = scan runs; 0 = counters hold, outputs blank
//   load       1-cycle strobe: capture cur_col/cur_row/mode into pending
//   cur_col    cursor column index
//   cur_row    cursor row index
//   mode       00 dot, 01 column bar, 10 row bar, 11 blinking dot
//   col_sel    one-hot active-high column enable
//   row_data   active-high row pattern for the selected column
//   frame_tick 1-cycle pulse when the scan wraps past the last column
//   range_err  sticky flag: a loaded cursor was out of range
module matrix_scan_selector #(
  parameter int N_COLS    = 7,
  parameter int N_ROWS    = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [$clog2(N_COLS)-1:0] cur_col,
  input  logic [$clog2(N_ROWS)-1:0] cur_row,
  input  logic [1:0]                mode,
  output logic [N_COLS-1:0]         col_sel,
  output logic [N_ROWS-1:0]         row_data,
  output logic                      frame_tick,
  output logic                      range_err
);

  localparam int CW = $clog2(N_COLS);
  localparam int RW = $clog2(N_ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] LAST_COL   = CW'(N_COLS - 1);
  localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_DOT   = 2'b00,
    MODE_COL   = 2'b01,
    MODE_ROW   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_t;

  logic [DW-1:0] dwell;
  logic [CW-1:0] scan_col;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic [CW-1:0] act_col,  pend_col;
  logic [RW-1:0] act_row,  pend_row;
  mode_t         act_mode, pend_mode;
  logic          pend_valid;

  logic              last_dwell;
  logic              wrap;
  logic              load_bad;
  logic              load_ok;
  logic              on_cursor;
  logic [N_COLS-1:0] col_pat;
  logic [N_ROWS-1:0] row_pat;

  always_comb begin
    last_dwell = (dwell == LAST_DWELL);
    // wrap marks the edge on which scan_col returns to 0; frame_tick is its
    // registered copy, and pending->active happens on this same edge so the
    // first column of the new frame already sees the new cursor.
    wrap       = en && last_dwell && (scan_col == LAST_COL);
    load_bad   = load && ((32'(cur_col) >= N_COLS) || (32'(cur_row) >= N_ROWS));
    load_ok    = load && !load_bad;
    on_cursor  = (scan_col == act_col);

    col_pat           = '0;
    col_pat[scan_col] = 1'b1;

    row_pat = '0;
    case (act_mode)
      MODE_DOT:   if (on_cursor) row_pat[act_row] = 1'b1;
      MODE_COL:   if (on_cursor) row_pat = '1;
      MODE_ROW:   row_pat[act_row] = 1'b1;
      MODE_BLINK: if (on_cursor && !blink_phase) row_pat[act_row] = 1'b1;
      default:    row_pat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell       <= '0;
      scan_col    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      act_col     <= '0;
      act_row     <= '0;
      act_mode    <= MODE_DOT;
      pend_col    <= '0;
      pend_row    <= '0;
      pend_mode   <= MODE_DOT;
      pend_valid  <= 1'b0;
      col_sel     <= '0;
      row_data    <= '0;
      frame_tick  <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      frame_tick <= wrap;

      if (en) begin
        col_sel  <= col_pat;
        row_data <= row_pat;
        if (last_dwell) begin
          dwell    <= '0;
          scan_col <= (scan_col == LAST_COL) ? '0 : scan_col + 1'b1;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end else begin
        col_sel  <= '0;
        row_data <= '0;
      end

      if (wrap) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        if (pend_valid) begin
          act_col  <= pend_col;
          act_row  <= pend_row;
          act_mode <= pend_mode;
        end
      end

      if (load_bad) range_err <= 1'b1;

      // A load on the wrap edge re-arms pending after the old value has been
      // transferred, so it lands one frame later.
      if (load_ok) begin
        pend_col   <= cur_col;
        pend_row   <= cur_row;
        pend_mode  <= mode_t'(mode);
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
